// File: rtl/add_pkg.sv
//------------------------------------------------------------------------------
// Module  : add_pkg
// Brief   : Shared types for the chunked sequential adder/subtractor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } add_op_t;

endpackage

`default_nettype wire

// File: rtl/add_chunk.sv
//------------------------------------------------------------------------------
// Module  : add_chunk
// Brief   : Combinational CHUNK-bit ripple adder; also exposes carry into MSB.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             co_msb_in
);

    logic [CHUNK:0] w_full;

    assign w_full    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    assign sum       = w_full[CHUNK-1:0];
    assign co        = w_full[CHUNK];
    // sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly
    assign co_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/add_chunked_seq.sv
//------------------------------------------------------------------------------
// Module  : add_chunked_seq
// Brief   : Multi-cycle WIDTH-bit add/sub, one CHUNK-bit slice per cycle, with
//           valid/ready handshakes. Define ADD_SAT_EN for saturating results.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module add_chunked_seq
    import add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int c_IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_err
            $error("add_chunked_seq: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    add_state_t        r_state;
    add_state_t        w_state_next;
    add_op_t           w_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [c_IDXW-1:0] r_idx;
    logic [WIDTH-1:0]  r_s;
    logic              r_cout;
    logic              r_ovf;

    logic [CHUNK-1:0]  w_a_sl;
    logic [CHUNK-1:0]  w_b_sl;
    logic [CHUNK-1:0]  w_sum;
    logic              w_co;
    logic              w_co_msb_in;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_s_wrap;
    logic [WIDTH-1:0]  w_s_fin;

    assign w_op = add_op_t'(sub);

    // Single shared slice adder; operands and result are steered by r_idx
    always_comb begin
        w_a_sl = r_a[CHUNK-1:0];
        w_b_sl = r_b[CHUNK-1:0];
        for (int k = 0; k < NCHUNK; k++) begin
            if (int'(r_idx) == k) begin
                w_a_sl = r_a[k*CHUNK +: CHUNK];
                w_b_sl = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a         (w_a_sl),
        .b         (w_b_sl),
        .ci        (r_carry),
        .sum       (w_sum),
        .co        (w_co),
        .co_msb_in (w_co_msb_in)
    );

    always_comb begin
        w_s_wrap = r_s;
        for (int k = 0; k < NCHUNK; k++) begin
            if (int'(r_idx) == k) begin
                w_s_wrap[k*CHUNK +: CHUNK] = w_sum;
            end
        end
    end

    // Only meaningful on the final slice, where it is the MSB carry-in/out disagreement
    assign w_ovf = w_co ^ w_co_msb_in;

`ifdef ADD_SAT_EN
    always_comb begin
        w_s_fin = w_s_wrap;
        if (w_ovf) begin
            w_s_fin = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_s_fin = w_s_wrap;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)         w_state_next = RUN;
            RUN:     if (r_idx == c_LAST)  w_state_next = DONE;
            DONE:    if (out_ready)        w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= in1;
                        r_b     <= (w_op == OP_SUB) ? ~in2 : in2;
                        r_carry <= (w_op == OP_SUB) ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_carry <= w_co;
                    if (r_idx == c_LAST) begin
                        r_s    <= w_s_fin;
                        r_cout <= w_co;
                        r_ovf  <= w_ovf;
                        r_idx  <= '0;
                    end else begin
                        r_s    <= w_s_wrap;
                        r_idx  <= r_idx + c_IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
